updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised successor to the team's 3-bit load/increment counter.
- Configurable width and terminal value (modulus), up and down counting, and selectable wrap or saturate mode.
- Overflow/underflow reporting is synthesisable hardware (pulse plus sticky flags) rather than a simulation-only message.
- Used as the general event/address counter in datapath and testbench-visible status logic.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, terminal count value; the count range is 0..MAX_VAL; must be <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of the count to 0.
- ld  in  1  synchronous load of data_in.
- data_in  in  WIDTH  load value.
- inc  in  1  count up by 1.
- dec  in  1  count down by 1.
- flag_clr  in  1  synchronous clear of all sticky flags.
- data_out  out  WIDTH  current count (registered).
- ovf  out  1  one-cycle pulse: an increment occurred at MAX_VAL.
- unf  out  1  one-cycle pulse: a decrement occurred at 0.
- ovf_sticky  out  1  latched ovf.
- unf_sticky  out  1  latched unf.
- ld_err_sticky  out  1  latched: a load value exceeded MAX_VAL.

Behaviour:
- Reset (rst=0, asynchronous): data_out=0, ovf=0, unf=0, all sticky flags=0. Outputs stay in that state while rst is low. Counting starts on the first clk edge after rst rises.
- All outputs are registered; every effect is visible after the same rising edge that samples the inputs.
- Priority per edge: clr > ld > (inc XOR dec). If inc and dec are both 1: data_out holds, no pulse.
- clr: data_out <= 0. No ovf/unf pulse.
- ld:
  - data_in <= MAX_VAL: data_out <= data_in.
  - data_in > MAX_VAL: data_out <= MAX_VAL and ld_err_sticky <= 1.
- inc only:
  - data_out < MAX_VAL: data_out+1.
  - data_out == MAX_VAL: ovf pulses for one cycle. Next value is 0 when SATURATE=0, MAX_VAL when SATURATE=1.
- dec only:
  - data_out > 0: data_out-1.
  - data_out == 0: unf pulses for one cycle. Next value is MAX_VAL when SATURATE=0, 0 when SATURATE=1.
- Arithmetic is computed WIDTH+1 bits wide; no unintended wrap when MAX_VAL = 2**WIDTH-1.
- ovf/unf are driven low on every edge that does not produce a new event.
- Sticky flags:
  - Set on their event; hold until flag_clr.
  - flag_clr and a new event on the same edge: the flag stays set (set wins).
  - clr does not affect sticky flags.
- Reset asserted mid-count clears everything immediately, independent of clk.
- No X propagation: with rst high, control inputs are treated as 0 when not driven high.

Decomposition:
- Package counter_pkg:
  - Mode constants CNT_WRAP=0 and CNT_SAT=1.
  - A function returning the next count given count, MAX_VAL, direction and mode; shared with the testbench reference model.
- One natural sub-module: cnt_sticky_flag, a 1-bit set-dominant latch with async active-low reset and sync clear. It is instantiated three times.

Test Plan:
- WIDTH=3, MAX_VAL=7, SATURATE=0: reset, then 8 inc cycles -> data_out 1..7 then 0; ovf high for exactly one cycle with data_out=0; ovf_sticky=1 afterwards.
- WIDTH=3, MAX_VAL=5, SATURATE=1: ld 5, then inc twice -> data_out stays 5; ovf pulses twice; dec from 0 -> data_out stays 0, unf=1.
- WIDTH=3, MAX_VAL=5, SATURATE=0: ld data_in=6 -> data_out=5, ld_err_sticky=1; then dec from 0 -> data_out=5, unf=1.
- Priority: clr=ld=inc=1 with data_out=4 -> data_out=0; ld=1, data_in=3, inc=1 -> 3; inc=dec=1 -> unchanged, no pulse.
- Sticky: flag_clr coincident with an overflow edge -> ovf_sticky remains 1; flag_clr alone next cycle -> 0.
- Async reset pulled low between clock edges with data_out=6 -> data_out=0 and flags=0 before the next edge; they stay 0 until rst=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared counter definitions: count modes and the next-count rule used by the
// counter datapath and by reference models.
package counter_pkg;

  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Widths up to 32 bits; the 33-bit form keeps cnt+1 exact at 2**32-1.
  function automatic logic [32:0] next_count(
    input logic [32:0] cnt,
    input logic [32:0] max_val,
    input logic        up,
    input logic        mode
  );
    logic [32:0] nxt;
    if (up) begin
      if (cnt >= max_val) begin
        nxt = (mode == CNT_SAT) ? max_val : 33'd0;
      end else begin
        nxt = cnt + 33'd1;
      end
    end else begin
      if (cnt == 33'd0) begin
        nxt = (mode == CNT_SAT) ? 33'd0 : max_val;
      end else begin
        nxt = cnt - 33'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cnt_sticky_flag.sv
// One-bit sticky status flag: set dominates a synchronous clear.
module cnt_sticky_flag (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_set,
  output logic o_q
);

  logic r_q;

  // Latch the event; a clear on the same edge as a new event loses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate at 0..MAX_VAL, plus
// overflow/underflow pulses and sticky status flags.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic [32:0] MAX_VAL  = (33'd1 << WIDTH) - 33'd1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  input  logic             inc,
  input  logic             dec,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf,
  output logic             unf,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             ld_err_sticky
);

  localparam logic           MODE    = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH:0] MAX_EXT = MAX_VAL[WIDTH:0];

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [32:0]      w_cnt_33;
  logic [32:0]      w_up_33;
  logic [32:0]      w_dn_33;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_ld_over;
  logic [WIDTH-1:0] w_nxt_cnt;
  logic             w_ovf_ev;
  logic             w_unf_ev;
  logic             w_ld_err_ev;
  logic             w_unused;

  assign w_cnt_33  = 33'(r_cnt);
  assign w_up_33   = next_count(w_cnt_33, MAX_VAL, 1'b1, MODE);
  assign w_dn_33   = next_count(w_cnt_33, MAX_VAL, 1'b0, MODE);
  assign w_at_max  = ({1'b0, r_cnt} == MAX_EXT);
  assign w_at_zero = (r_cnt == {WIDTH{1'b0}});
  assign w_ld_over = ({1'b0, data_in} > MAX_EXT);
  assign w_unused  = ^{w_up_33[32:WIDTH], w_dn_33[32:WIDTH]};

  // Next count and events; priority clr > ld > a lone inc or dec.
  always_comb begin
    w_nxt_cnt   = r_cnt;
    w_ovf_ev    = 1'b0;
    w_unf_ev    = 1'b0;
    w_ld_err_ev = 1'b0;
    if (clr == 1'b1) begin
      w_nxt_cnt = {WIDTH{1'b0}};
    end else if (ld == 1'b1) begin
      if (w_ld_over) begin
        w_nxt_cnt   = MAX_EXT[WIDTH-1:0];
        w_ld_err_ev = 1'b1;
      end else begin
        w_nxt_cnt = data_in;
      end
    end else if ((inc == 1'b1) && (dec != 1'b1)) begin
      w_nxt_cnt = w_up_33[WIDTH-1:0];
      w_ovf_ev  = w_at_max;
    end else if ((dec == 1'b1) && (inc != 1'b1)) begin
      w_nxt_cnt = w_dn_33[WIDTH-1:0];
      w_unf_ev  = w_at_zero;
    end else begin
      w_nxt_cnt = r_cnt;
    end
  end

  // Count register and single-cycle event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {WIDTH{1'b0}};
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cnt <= w_nxt_cnt;
      r_ovf <= w_ovf_ev;
      r_unf <= w_unf_ev;
    end
  end

  cnt_sticky_flag u_ovf_sticky (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (flag_clr),
    .i_set   (w_ovf_ev),
    .o_q     (ovf_sticky)
  );

  cnt_sticky_flag u_unf_sticky (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (flag_clr),
    .i_set   (w_unf_ev),
    .o_q     (unf_sticky)
  );

  cnt_sticky_flag u_ld_err_sticky (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (flag_clr),
    .i_set   (w_ld_err_ev),
    .o_q     (ld_err_sticky)
  );

  assign data_out = r_cnt;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: three counter configurations share one stimulus stream;
// each directed step queues the hand-computed response of one configuration.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       ld;
  logic       inc;
  logic       dec;
  logic       flag_clr;
  logic [2:0] data_in;

  logic [2:0] cnt_o [3];
  logic       ovf_o [3];
  logic       unf_o [3];
  logic       ovs_o [3];
  logic       uns_o [3];
  logic       lds_o [3];

  int n_checks = 0;
  int n_errors = 0;

  // exp packs {count[2:0], ovf, unf, ovf_sticky, unf_sticky, ld_err_sticky}
  typedef struct {
    int         dut;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  // u0: W3 MAX7 wrap, u1: W3 MAX5 saturate, u2: W3 MAX5 wrap
  updown_counter_param #(.WIDTH(3), .MAX_VAL(33'd7), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .data_in(data_in), .inc(inc), .dec(dec),
    .flag_clr(flag_clr), .data_out(cnt_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]),
    .ovf_sticky(ovs_o[0]), .unf_sticky(uns_o[0]), .ld_err_sticky(lds_o[0])
  );

  updown_counter_param #(.WIDTH(3), .MAX_VAL(33'd5), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .data_in(data_in), .inc(inc), .dec(dec),
    .flag_clr(flag_clr), .data_out(cnt_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]),
    .ovf_sticky(ovs_o[1]), .unf_sticky(uns_o[1]), .ld_err_sticky(lds_o[1])
  );

  updown_counter_param #(.WIDTH(3), .MAX_VAL(33'd5), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .data_in(data_in), .inc(inc), .dec(dec),
    .flag_clr(flag_clr), .data_out(cnt_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]),
    .ovf_sticky(ovs_o[2]), .unf_sticky(uns_o[2]), .ld_err_sticky(lds_o[2])
  );

  function automatic logic [7:0] act(input int d);
    return {cnt_o[d], ovf_o[d], unf_o[d], ovs_o[d], uns_o[d], lds_o[d]};
  endfunction

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got cnt=%0d flags(o,u,os,us,ls)=%b, expected cnt=%0d flags=%b",
               nm, a[7:5], a[4:0], e[7:5], e[4:0]);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response of one DUT.
  task automatic step(input logic c, input logic l, input logic [2:0] d, input logic i,
                      input logic dn, input logic f, input int dut,
                      input logic [2:0] ec, input logic [4:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    clr = c; ld = l; data_in = d; inc = i; dec = dn; flag_clr = f;
    e.dut = dut;
    e.exp = {ec, ef};
    e.name = nm;
    sb_q.push_back(e);
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, act(e.dut), e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0; flag_clr = 1'b0;
    data_in = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_state", act(d), 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // full-range wrap on u0
    for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 3'(k), 5'b00000, "a_inc");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 3'd0, 5'b10100, "a_ovf_wrap");
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 3'd0, 5'b00100, "a_ovf_one_cycle");

    // saturate on u1
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 5'b00000, "b_sync");
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1, 3'd5, 5'b00000, "b_ld5");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1, 3'd5, 5'b10100, "b_sat_inc1");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1, 3'd5, 5'b10100, "b_sat_inc2");
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 5'b00100, "b_clr");
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1, 3'd0, 5'b01110, "b_sat_dec0");

    // load error and down-wrap on u2
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2, 3'd0, 5'b00000, "c_sync");
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 2, 3'd5, 5'b00001, "c_ld_over");
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2, 3'd0, 5'b00001, "c_clr_keeps_sticky");
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2, 3'd5, 5'b01011, "c_dec_wrap");
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2, 3'd4, 5'b00011, "c_dec");

    // priority on u2
    step(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 2, 3'd0, 5'b00011, "d_clr_wins");
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 2, 3'd3, 5'b00011, "d_ld_wins");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2, 3'd3, 5'b00011, "d_inc_dec_hold");

    // sticky set-wins on u2
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 2, 3'd5, 5'b00011, "e_ld5");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 2, 3'd0, 5'b10100, "e_set_wins");
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2, 3'd0, 5'b00000, "e_flag_clr");

    // asynchronous reset on u0 mid-count
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 0, 3'd0, 5'b00000, "f_sync");
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 0, 3'd7, 5'b00000, "f_ld7");
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 3'd0, 5'b10100, "f_ovf");
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 0, 3'd6, 5'b00100, "f_ld6");
    @(negedge clk);
    clr = 1'b0; ld = 1'b0; data_in = 3'd0; inc = 1'b0; dec = 1'b0; flag_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("f_async_reset_now", act(d), 8'h00);
    @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) chk("f_async_reset_held", act(d), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 3'd1, 5'b00000, "f_count_after_release");
    @(negedge clk);
    inc = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
